aor_result_checker: RTL and testbench

- Downstream consumer of the locked 16-bit lower-part-OR carry-lookahead adder (32-bit key).
- Captures each operand pair and the locked adder's result, then recomputes the golden approximate sum with a reference model.
- Compares the two results and accumulates a pass/fail verdict over a run of NUM_VEC vectors.
- Used in gate-level and locked-netlist simulation, and on-chip, to decide whether the applied key unlocks correct behaviour.

---
 rtl/aor_check_pkg.sv | 33 +++
 rtl/aor_golden_model.sv | 30 +++
 rtl/aor_result_checker.sv | 180 ++++++++++++++++++
 tb/tb_aor_result_checker.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aor_check_pkg.sv
// Shared definitions for the lower-part-OR adder result checker.
// Holds default widths, the checker FSM state type and width helper functions.
package aor_check_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_LOWER_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of an adder result: one carry bit above the operand width.
  function automatic int unsigned sum_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

  // Width of a captured {add1, add2, result} triple.
  function automatic int unsigned triple_w(input int unsigned data_w);
    return 3 * data_w + 1;
  endfunction

  // Bits needed to hold the values 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'(1) << w) <= 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/aor_golden_model.sv
// Reference model of the lower-part-OR approximate adder (combinational).
// Ports: a_i, b_i   operands (DATA_W bits)
//        golden_c   approximate sum (DATA_W+1 bits)
module aor_golden_model #(
  parameter int unsigned DATA_W  = aor_check_pkg::DEF_DATA_W,
  parameter int unsigned LOWER_W = aor_check_pkg::DEF_LOWER_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W:0]   golden_c
);

  localparam int unsigned HIGH_W     = DATA_W - LOWER_W;
  localparam int unsigned HIGH_SUM_W = HIGH_W + 1;

  logic [LOWER_W-1:0]    low;
  logic                  cin;
  logic [HIGH_SUM_W-1:0] high;

  // Low bits are ORed; the top OR position's AND feeds the exact upper adder.
  always_comb begin
    low      = a_i[LOWER_W-1:0] | b_i[LOWER_W-1:0];
    cin      = a_i[LOWER_W-1] & b_i[LOWER_W-1];
    high     = HIGH_SUM_W'(a_i[DATA_W-1:LOWER_W])
             + HIGH_SUM_W'(b_i[DATA_W-1:LOWER_W])
             + HIGH_SUM_W'(cin);
    golden_c = {high, low};
  end

endmodule

// File: rtl/aor_result_checker.sv
// Checks a locked approximate adder against the golden model over a run of
// NUM_VEC vectors and accumulates a pass/fail verdict.
// Ports: clk_i, rst_i (sync, active high), start_i (run start pulse),
//        in_valid_i/in_ready_o with add1_i, add2_i, result_i (triple handshake),
//        busy_o, done_o (end pulse), pass_o (sticky verdict),
//        err_cnt_o, vec_cnt_o (run counters), first_fail_o (first bad triple).
module aor_result_checker
  import aor_check_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned LOWER_W = DEF_LOWER_W,
  parameter int unsigned NUM_VEC = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DATA_W-1:0]   add1_i,
  input  logic [DATA_W-1:0]   add2_i,
  input  logic [DATA_W:0]     result_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [CNT_W-1:0]    err_cnt_o,
  output logic [CNT_W-1:0]    vec_cnt_o,
  output logic [3*DATA_W:0]   first_fail_o
);

  localparam int unsigned      SUM_W    = sum_w(DATA_W);
  localparam int unsigned      TRIPLE_W = triple_w(DATA_W);
  localparam int unsigned      ACC_W    = cnt_w(NUM_VEC);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(NUM_VEC - 1);

  state_e                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]      vec_cnt_q, vec_cnt_d;
  logic [TRIPLE_W-1:0]   first_fail_q, first_fail_d;
  logic [ACC_W-1:0]      acc_cnt_q, acc_cnt_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [TRIPLE_W-1:0]   s1_triple_q, s1_triple_d;
  logic                  s2_vld_q, s2_vld_d;
  logic                  s2_mis_q, s2_mis_d;
  logic [TRIPLE_W-1:0]   s2_triple_q, s2_triple_d;

  logic                  accept;
  logic [DATA_W-1:0]     s1_a, s1_b;
  logic [SUM_W-1:0]      s1_res, s1_golden;

  // Triple layout is {add1, add2, result}.
  assign s1_a   = s1_triple_q[TRIPLE_W-1 -: DATA_W];
  assign s1_b   = s1_triple_q[SUM_W +: DATA_W];
  assign s1_res = s1_triple_q[SUM_W-1:0];

  aor_golden_model #(
    .DATA_W  (DATA_W),
    .LOWER_W (LOWER_W)
  ) u_golden (
    .a_i      (s1_a),
    .b_i      (s1_b),
    .golden_c (s1_golden)
  );

  // Pipeline, counters and FSM next-state.
  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    vec_cnt_d    = vec_cnt_q;
    first_fail_d = first_fail_q;
    acc_cnt_d    = acc_cnt_q;

    accept      = in_valid_i & in_ready_q;
    s1_vld_d    = accept;
    s1_triple_d = accept ? {add1_i, add2_i, result_i} : s1_triple_q;
    s2_vld_d    = s1_vld_q;
    s2_mis_d    = s1_vld_q & (s1_golden != s1_res);
    s2_triple_d = s1_vld_q ? s1_triple_q : s2_triple_q;

    // Counter update from the registered compare result.
    if (s2_vld_q) begin
      vec_cnt_d = vec_cnt_q + CNT_W'(1);
      if (s2_mis_q) begin
        if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (err_cnt_q == '0)      first_fail_d = s2_triple_q;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d      = RUN;
          in_ready_d   = 1'b1;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          err_cnt_d    = '0;
          vec_cnt_d    = '0;
          first_fail_d = '0;
          acc_cnt_d    = '0;
        end
      end
      RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + ACC_W'(1);
          if (acc_cnt_q == ACC_LAST) begin
            state_d    = DRAIN;
            in_ready_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        // Last vector's counter update has landed once both stages are empty.
        if (!s1_vld_q && !s2_vld_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_cnt_q == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      vec_cnt_q    <= '0;
      first_fail_q <= '0;
      acc_cnt_q    <= '0;
      s1_vld_q     <= 1'b0;
      s1_triple_q  <= '0;
      s2_vld_q     <= 1'b0;
      s2_mis_q     <= 1'b0;
      s2_triple_q  <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      vec_cnt_q    <= vec_cnt_d;
      first_fail_q <= first_fail_d;
      acc_cnt_q    <= acc_cnt_d;
      s1_vld_q     <= s1_vld_d;
      s1_triple_q  <= s1_triple_d;
      s2_vld_q     <= s2_vld_d;
      s2_mis_q     <= s2_mis_d;
      s2_triple_q  <= s2_triple_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_cnt_o    = err_cnt_q;
  assign vec_cnt_o    = vec_cnt_q;
  assign first_fail_o = first_fail_q;

endmodule

// File: tb/tb_aor_result_checker.sv
// Bench for aor_result_checker: three instances (NUM_VEC=1, NUM_VEC=16,
// NUM_VEC=6 with 2-bit counters) share stimulus and are checked every cycle
// against a transaction-timeline model, plus directed literal expectations.
module tb_aor_result_checker;

  logic        clk;
  logic        rst;
  logic [2:0]  start;
  logic        valid;
  logic [15:0] a, b;
  logic [16:0] res;

  logic        rdy0, rdy1, rdy2, busy0, busy1, busy2;
  logic        done0, done1, done2, pass0, pass1, pass2;
  logic [7:0]  err0, err1, vec0, vec1;
  logic [1:0]  err2, vec2;
  logic [48:0] ff0, ff1, ff2;

  logic        rdy_a[3], busy_a[3], done_a[3], pass_a[3];
  logic [7:0]  err_a[3], vec_a[3];
  logic [48:0] ff_a[3];

  int checks = 0;
  int failures = 0;

  aor_result_checker #(.DATA_W(16), .LOWER_W(4), .NUM_VEC(1), .CNT_W(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .in_valid_i(valid), .in_ready_o(rdy0),
    .add1_i(a), .add2_i(b), .result_i(res), .busy_o(busy0), .done_o(done0),
    .pass_o(pass0), .err_cnt_o(err0), .vec_cnt_o(vec0), .first_fail_o(ff0));

  aor_result_checker #(.DATA_W(16), .LOWER_W(4), .NUM_VEC(16), .CNT_W(8)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .in_valid_i(valid), .in_ready_o(rdy1),
    .add1_i(a), .add2_i(b), .result_i(res), .busy_o(busy1), .done_o(done1),
    .pass_o(pass1), .err_cnt_o(err1), .vec_cnt_o(vec1), .first_fail_o(ff1));

  aor_result_checker #(.DATA_W(16), .LOWER_W(4), .NUM_VEC(6), .CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .in_valid_i(valid), .in_ready_o(rdy2),
    .add1_i(a), .add2_i(b), .result_i(res), .busy_o(busy2), .done_o(done2),
    .pass_o(pass2), .err_cnt_o(err2), .vec_cnt_o(vec2), .first_fail_o(ff2));

  always_comb begin
    rdy_a  = '{rdy0, rdy1, rdy2};
    busy_a = '{busy0, busy1, busy2};
    done_a = '{done0, done1, done2};
    pass_a = '{pass0, pass1, pass2};
    err_a  = '{err0, err1, {6'd0, err2}};
    vec_a  = '{vec0, vec1, {6'd0, vec2}};
    ff_a   = '{ff0, ff1, ff2};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Approximate sum from the adder's definition: OR low nibble, exact upper add.
  function automatic logic [16:0] ref_sum(input logic [15:0] x, input logic [15:0] y);
    int lo, hi, cin;
    lo  = int'(x & y | x ^ y) & 32'hF;
    cin = int'(x[3] & y[3]);
    hi  = int'(x >> 4) + int'(y >> 4) + cin;
    return 17'((hi << 4) | lo);
  endfunction

  function automatic logic [15:0] gen_a(input int k);
    return 16'(k * 32'h1357 + 32'h0F0F);
  endfunction

  function automatic logic [15:0] gen_b(input int k);
    return 16'(k * 32'h2468 + 32'h8421);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  int          nv[3]   = '{1, 16, 6};
  int          cmod[3] = '{256, 256, 4};
  bit          chk_en = 1'b0;
  longint      edge_n = 0;
  bit          m_idle[3], m_in_done[3], m_ready[3], m_busy[3], m_done[3], m_pass[3];
  int          m_err[3], m_vec[3], m_acc[3];
  logic [48:0] m_ff[3];
  longint      m_done_at[3];
  longint      acc_edge[3][16];
  logic [15:0] ta[3][16], tb_[3][16];
  logic [16:0] tr[3][16];

  always @(posedge clk) begin
    edge_n++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        chk_en       = 1'b1;
        m_idle[i]    = 1'b1; m_in_done[i] = 1'b0;
        m_ready[i]   = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_pass[i] = 1'b0;
        m_err[i]     = 0; m_vec[i] = 0; m_acc[i] = 0; m_ff[i] = '0;
        m_done_at[i] = -1;
      end else begin
        m_done[i] = 1'b0;
        // Vectors accepted two edges ago show up in the counters now.
        for (int k = 0; k < 16; k++) begin
          if (k < m_acc[i] && acc_edge[i][k] == edge_n - 2) begin
            m_vec[i] = (m_vec[i] + 1) % cmod[i];
            if (ref_sum(ta[i][k], tb_[i][k]) != tr[i][k]) begin
              if (m_err[i] == 0) m_ff[i] = {ta[i][k], tb_[i][k], tr[i][k]};
              if (m_err[i] < cmod[i] - 1) m_err[i]++;
            end
          end
        end
        if (m_ready[i] && valid) begin
          acc_edge[i][m_acc[i]] = edge_n;
          ta[i][m_acc[i]]  = a;
          tb_[i][m_acc[i]] = b;
          tr[i][m_acc[i]]  = res;
          m_acc[i]++;
          if (m_acc[i] == nv[i]) begin
            m_ready[i]   = 1'b0;
            m_done_at[i] = edge_n + 3;
          end
        end
        if (m_done_at[i] == edge_n) begin
          m_done[i]    = 1'b1;
          m_pass[i]    = (m_err[i] == 0);
          m_busy[i]    = 1'b0;
          m_done_at[i] = -1;
          m_in_done[i] = 1'b1;
        end else if (m_in_done[i]) begin
          m_in_done[i] = 1'b0;
          m_idle[i]    = 1'b1;
        end else if (m_idle[i] && start[i]) begin
          m_idle[i]  = 1'b0;
          m_ready[i] = 1'b1; m_busy[i] = 1'b1; m_pass[i] = 1'b0;
          m_err[i]   = 0; m_vec[i] = 0; m_ff[i] = '0; m_acc[i] = 0;
        end
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("ready%0d", i), 64'(rdy_a[i]),  64'(m_ready[i]));
        chk($sformatf("busy%0d", i),  64'(busy_a[i]), 64'(m_busy[i]));
        chk($sformatf("done%0d", i),  64'(done_a[i]), 64'(m_done[i]));
        chk($sformatf("pass%0d", i),  64'(pass_a[i]), 64'(m_pass[i]));
        chk($sformatf("err%0d", i),   64'(err_a[i]),  64'(m_err[i]));
        chk($sformatf("vec%0d", i),   64'(vec_a[i]),  64'(m_vec[i]));
        chk($sformatf("ff%0d", i),    64'(ff_a[i]),   64'(m_ff[i]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    while (!done_a[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_seen%0d", i), 64'(done_a[i]), 64'(1));
  endtask

  task automatic one_vec(input logic [15:0] x, input logic [15:0] y, input logic [16:0] r);
    a = x; b = y; res = r; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    int acc;
    logic [48:0] ff_exp;
    rst = 1'b1; start = '0; valid = 1'b0; a = '0; b = '0; res = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy1", 64'(busy_a[1]), 64'(0));
    chk("rst_ff1",   64'(ff_a[1]),   64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Correct single vector: done three edges after the accept edge.
    pulse_start(0);
    one_vec(16'h29AF, 16'h7A1B, 17'h0A3CF);
    chk("t1_done_T1", 64'(done_a[0]), 64'(0));
    @(negedge clk);
    @(negedge clk);
    chk("t1_vec_T2",  64'(vec_a[0]),  64'(1));
    chk("t1_done_T2", 64'(done_a[0]), 64'(0));
    @(negedge clk);
    chk("t1_done_T3", 64'(done_a[0]), 64'(1));
    chk("t1_pass",    64'(pass_a[0]), 64'(1));
    chk("t1_err",     64'(err_a[0]),  64'(0));
    @(negedge clk);

    // Wrong-key response.
    pulse_start(0);
    one_vec(16'h8943, 16'hFFFF, 17'h1893E);
    wait_done(0, 10);
    chk("t2_err",  64'(err_a[0]),  64'(1));
    chk("t2_pass", 64'(pass_a[0]), 64'(0));
    chk("t2_ff",   64'(ff_a[0]),   64'({16'h8943, 16'hFFFF, 17'h1893E}));
    @(negedge clk);

    // Boundary: OR of complementary low bits, no carry into upper part.
    pulse_start(0);
    one_vec(16'h5555, 16'hAAAA, 17'h0FFFF);
    wait_done(0, 10);
    chk("t3_pass_ok", 64'(pass_a[0]), 64'(1));
    @(negedge clk);
    pulse_start(0);
    one_vec(16'h5555, 16'hAAAA, 17'h10000);
    wait_done(0, 10);
    chk("t3_pass_bad", 64'(pass_a[0]), 64'(0));
    chk("t3_err_bad",  64'(err_a[0]),  64'(1));
    @(negedge clk);

    // Sixteen back-to-back vectors, two corrupt, start pulse mid-run ignored.
    pulse_start(1);
    acc = 0;
    for (int k = 0; k < 18; k++) begin
      a = gen_a(k); b = gen_b(k);
      res = ref_sum(a, b) ^ ((k == 3 || k == 9) ? 17'h1 : 17'h0);
      valid = 1'b1;
      start[1] = (k == 7);
      if (rdy_a[1]) acc++;
      @(negedge clk);
    end
    valid = 1'b0; start = '0;
    chk("t4_accepts", 64'(acc), 64'(16));
    wait_done(1, 20);
    ff_exp = {gen_a(3), gen_b(3), ref_sum(gen_a(3), gen_b(3)) ^ 17'h1};
    chk("t4_vec",  64'(vec_a[1]),  64'(16));
    chk("t4_err",  64'(err_a[1]),  64'(2));
    chk("t4_ff",   64'(ff_a[1]),   64'(ff_exp));
    chk("t4_pass", 64'(pass_a[1]), 64'(0));
    @(negedge clk);

    // Reset after five accepts; start asserted with reset must lose.
    pulse_start(1);
    for (int k = 0; k < 5; k++) begin
      a = gen_a(k + 20); b = gen_b(k + 20); res = 17'h0; valid = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1; start[1] = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = '0; valid = 1'b0;
    chk("t5_rst_busy", 64'(busy_a[1]), 64'(0));
    chk("t5_rst_rdy",  64'(rdy_a[1]),  64'(0));
    chk("t5_rst_err",  64'(err_a[1]),  64'(0));
    chk("t5_rst_vec",  64'(vec_a[1]),  64'(0));
    repeat (8) @(negedge clk);
    pulse_start(1);
    for (int k = 0; k < 16; k++) begin
      a = gen_a(k + 40); b = gen_b(k + 40); res = ref_sum(a, b); valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    wait_done(1, 20);
    chk("t5_vec",  64'(vec_a[1]),  64'(16));
    chk("t5_err",  64'(err_a[1]),  64'(0));
    chk("t5_pass", 64'(pass_a[1]), 64'(1));
    @(negedge clk);

    // Saturating 2-bit error counter, wrapping vector counter.
    pulse_start(2);
    for (int k = 0; k < 6; k++) begin
      a = gen_a(k + 60); b = gen_b(k + 60); res = ref_sum(a, b) ^ 17'h10000; valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    wait_done(2, 20);
    chk("t6_err",  64'(err_a[2]),  64'(3));
    chk("t6_vec",  64'(vec_a[2]),  64'(2));
    chk("t6_pass", 64'(pass_a[2]), 64'(0));
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
